// File: rtl/hdc_pkg.sv
// Shared HDC types: search FSM state encoding and a ceiling-divide helper.
// Pure declarations; no latency, no flow control.
package hdc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        COMPARE = 2'd2
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

// File: rtl/hamming_chunk.sv
// Masked PAR_BITS-wide XOR + popcount of one chunk; combinational, zero latency.
// No flow control: result is valid whenever inputs are.
module hamming_chunk #(
    parameter int DIMENSIONS = 6,
    parameter int PAR_BITS   = 2,
    parameter int BASE_W     = 3,
    parameter int CNT_W      = $clog2(PAR_BITS + 1)
) (
    input  logic [PAR_BITS-1:0] a,
    input  logic [PAR_BITS-1:0] b,
    input  logic [BASE_W-1:0]   base,
    output logic [CNT_W-1:0]    count
);

    logic [PAR_BITS-1:0] diff;

    // Bits whose absolute position is at or above DIMENSIONS are padding.
    always_comb begin
        diff  = '0;
        count = '0;
        for (int i = 0; i < PAR_BITS; i++) begin
            diff[i] = (a[i] ^ b[i]) & ((int'(base) + i) < DIMENSIONS);
            count   = count + CNT_W'(diff[i]);
        end
    end

endmodule

// File: rtl/am_search.sv
// Associative-memory search: nearest class hypervector by Hamming distance.
// Latency ceil(DIMENSIONS/PAR_BITS)+1 cycles from en to out; en is ignored while busy.
module am_search
    import hdc_pkg::*;
#(
    parameter int DIMENSIONS  = 6,
    parameter int NUM_CLASSES = 3,
    parameter int PAR_BITS    = 2
) (
    input  logic                                     clk,
    input  logic                                     nrst,
    input  logic                                     en,
    input  logic [DIMENSIONS-1:0]                    hv_query,
    input  logic [NUM_CLASSES-1:0][DIMENSIONS-1:0]   class_hvs,
    output logic                                     out,
    output logic [$clog2(NUM_CLASSES)-1:0]           class_out,
    output logic [$clog2(DIMENSIONS+1)-1:0]          dist_out
);

    localparam int N   = ceil_div(DIMENSIONS, PAR_BITS);
    localparam int PW  = N * PAR_BITS;
    localparam int CW  = $clog2(NUM_CLASSES);
    localparam int DW  = $clog2(DIMENSIONS + 1);
    localparam int KW  = (N > 1) ? $clog2(N) : 1;
    localparam int BW  = $clog2(PW + 1);
    localparam int PCW = $clog2(PAR_BITS + 1);

    state_t state, nstate;

    logic [KW-1:0]                       cnt;
    logic                                last_chunk;
    logic [BW-1:0]                       base;
    logic [PW-1:0]                       q_reg;
    logic [NUM_CLASSES-1:0][PW-1:0]      c_reg;
    logic [NUM_CLASSES-1:0][DW-1:0]      acc;
    logic [NUM_CLASSES-1:0][PCW-1:0]     pc;
    logic [CW-1:0]                       best_idx;
    logic [DW-1:0]                       best_d;

    assign last_chunk = (cnt == KW'(N - 1));
    assign base       = BW'(int'(cnt) * PAR_BITS);

    // Captured vectors shift right each COMPUTE cycle so the live chunk is always at the LSBs.
    for (genvar g = 0; g < NUM_CLASSES; g++) begin : g_chunk
        hamming_chunk #(
            .DIMENSIONS (DIMENSIONS),
            .PAR_BITS   (PAR_BITS),
            .BASE_W     (BW),
            .CNT_W      (PCW)
        ) u_chunk (
            .a     (q_reg[PAR_BITS-1:0]),
            .b     (c_reg[g][PAR_BITS-1:0]),
            .base  (base),
            .count (pc[g])
        );
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        case (state)
            IDLE:    if (en) nstate = COMPUTE;
            COMPUTE: if (last_chunk) nstate = COMPARE;
            COMPARE: nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    // Argmin: strict less-than keeps the lowest index on ties.
    always_comb begin
        best_idx = '0;
        best_d   = acc[0];
        for (int c = 1; c < NUM_CLASSES; c++) begin
            if (acc[c] < best_d) begin
                best_d   = acc[c];
                best_idx = CW'(c);
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cnt       <= '0;
            q_reg     <= '0;
            c_reg     <= '0;
            acc       <= '0;
            out       <= 1'b0;
            class_out <= '0;
            dist_out  <= '0;
        end else begin
            out <= 1'b0;
            case (state)
                IDLE: begin
                    if (en) begin
                        q_reg <= PW'(hv_query);
                        for (int c = 0; c < NUM_CLASSES; c++) begin
                            c_reg[c] <= PW'(class_hvs[c]);
                        end
                        acc <= '0;
                        cnt <= '0;
                    end
                end
                COMPUTE: begin
                    q_reg <= q_reg >> PAR_BITS;
                    for (int c = 0; c < NUM_CLASSES; c++) begin
                        c_reg[c] <= c_reg[c] >> PAR_BITS;
                        acc[c]   <= acc[c] + DW'(pc[c]);
                    end
                    cnt <= cnt + KW'(1);
                end
                COMPARE: begin
                    class_out <= best_idx;
                    dist_out  <= best_d;
                    out       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
